// File: rtl/win_check_sequencer.sv
// Serial connect-four win detector: walks the four lines through a dropped piece, one board probe per cycle; WIN_DIR_EN adds win_dir.
// Latency: done pulses the cycle after the last probe (empty player: next cycle); start is ignored while busy, no queueing.
module win_check_sequencer #(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int WIN_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] start_row,
    input  logic [2:0] start_col,
    input  logic [1:0] player,
    output logic [2:0] rd_row,
    output logic [2:0] rd_col,
    output logic       rd_valid,
    input  logic [1:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       win
`ifdef WIN_DIR_EN
    ,
    output logic [1:0] win_dir
`endif
);

    localparam logic [3:0] ROWS4 = 4'(ROWS);
    localparam logic [3:0] COLS4 = 4'(COLS);
    localparam logic [3:0] WIN4  = 4'(WIN_LEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state_q, state_n;
    logic [2:0] row_q, row_n;
    logic [2:0] col_q, col_n;
    logic [1:0] player_q, player_n;
    logic [1:0] dir_q, dir_n;
    logic       side_q, side_n;
    logic [3:0] k_q, k_n;
    logic [3:0] count_q, count_n;
    logic       win_q, win_n;
`ifdef WIN_DIR_EN
    logic [1:0] win_dir_q, win_dir_n;
`endif

    logic              row_up, row_dn, col_up, col_dn;
    logic signed [3:0] k_s;
    logic signed [3:0] probe_row, probe_col;
    logic              in_bounds;
    logic              match;
    logic              end_side;

    // Side 1 walks the same line in the opposite direction.
    always_comb begin
        row_up = (dir_q != 2'd0) && !side_q;
        row_dn = (dir_q != 2'd0) && side_q;
        col_up = ((dir_q == 2'd0 || dir_q == 2'd2) && !side_q) || (dir_q == 2'd3 && side_q);
        col_dn = ((dir_q == 2'd0 || dir_q == 2'd2) && side_q) || (dir_q == 2'd3 && !side_q);
    end

    // 4-bit signed probe: stepping off the board lands on -1 or 8 (wraps to -8), both negative or out of range.
    always_comb begin
        k_s       = signed'(k_q);
        probe_row = signed'({1'b0, row_q}) + (row_up ? k_s : (row_dn ? -k_s : 4'sd0));
        probe_col = signed'({1'b0, col_q}) + (col_up ? k_s : (col_dn ? -k_s : 4'sd0));
        in_bounds = !probe_row[3] && ($unsigned(probe_row) < ROWS4) &&
                    !probe_col[3] && ($unsigned(probe_col) < COLS4);
    end

    always_comb begin
        rd_valid = (state_q == ST_SCAN) && in_bounds;
        rd_row   = (state_q == ST_SCAN) ? probe_row[2:0] : 3'd0;
        rd_col   = (state_q == ST_SCAN) ? probe_col[2:0] : 3'd0;
        match    = rd_valid && (rd_data == player_q);
        busy     = (state_q != ST_IDLE);
        done     = (state_q == ST_DONE);
        win      = win_q;
    end

`ifdef WIN_DIR_EN
    assign win_dir = win_dir_q;
`endif

    always_comb begin
        state_n  = state_q;
        row_n    = row_q;
        col_n    = col_q;
        player_n = player_q;
        dir_n    = dir_q;
        side_n   = side_q;
        k_n      = k_q;
        count_n  = count_q;
        win_n    = win_q;
`ifdef WIN_DIR_EN
        win_dir_n = win_dir_q;
`endif
        end_side = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    win_n = 1'b0;
`ifdef WIN_DIR_EN
                    win_dir_n = 2'd0;
`endif
                    if (player != 2'b00) begin
                        row_n    = start_row;
                        col_n    = start_col;
                        player_n = player;
                        dir_n    = 2'd0;
                        side_n   = 1'b0;
                        k_n      = 4'd1;
                        count_n  = 4'd1;
                        state_n  = ST_SCAN;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
            end

            ST_SCAN: begin
                if (match) begin
                    if (count_q + 4'd1 == WIN4) begin
                        win_n   = 1'b1;
`ifdef WIN_DIR_EN
                        win_dir_n = dir_q;
`endif
                        state_n = ST_DONE;
                    end else begin
                        count_n = count_q + 4'd1;
                        if (k_q + 4'd1 == WIN4) begin
                            end_side = 1'b1;
                        end else begin
                            k_n = k_q + 4'd1;
                        end
                    end
                end else begin
                    end_side = 1'b1;
                end

                // count carries over into the second side of the same line.
                if (end_side) begin
                    k_n = 4'd1;
                    if (!side_q) begin
                        side_n = 1'b1;
                    end else begin
                        side_n  = 1'b0;
                        count_n = 4'd1;
                        dir_n   = dir_q + 2'd1;
                        if (dir_q == 2'd3) begin
                            win_n   = 1'b0;
                            state_n = ST_DONE;
                        end
                    end
                end
            end

            ST_DONE: begin
                state_n = ST_IDLE;
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            row_q    <= 3'd0;
            col_q    <= 3'd0;
            player_q <= 2'd0;
            dir_q    <= 2'd0;
            side_q   <= 1'b0;
            k_q      <= 4'd0;
            count_q  <= 4'd0;
            win_q    <= 1'b0;
`ifdef WIN_DIR_EN
            win_dir_q <= 2'd0;
`endif
        end else begin
            state_q  <= state_n;
            row_q    <= row_n;
            col_q    <= col_n;
            player_q <= player_n;
            dir_q    <= dir_n;
            side_q   <= side_n;
            k_q      <= k_n;
            count_q  <= count_n;
            win_q    <= win_n;
`ifdef WIN_DIR_EN
            win_dir_q <= win_dir_n;
`endif
        end
    end

endmodule

// File: tb/tb_win_check_sequencer.sv
// Bench for win_check_sequencer: fixed board scenarios, start/reset corner cases and random boards against a line-walking model.
module tb_win_check_sequencer;

    localparam int WL = 4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] start_row;
    logic [2:0] start_col;
    logic [1:0] player;
    logic [2:0] rd_row;
    logic [2:0] rd_col;
    logic       rd_valid;
    logic [1:0] rd_data;
    logic       busy;
    logic       done;
    logic       win;
`ifdef WIN_DIR_EN
    logic [1:0] win_dir;
`endif

    win_check_sequencer #(.ROWS(8), .COLS(8), .WIN_LEN(WL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .start_row (start_row),
        .start_col (start_col),
        .player    (player),
        .rd_row    (rd_row),
        .rd_col    (rd_col),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .win       (win)
`ifdef WIN_DIR_EN
        ,
        .win_dir   (win_dir)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] board [0:7][0:7];
    always_comb rd_data = board[rd_row][rd_col];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference model: expected probe list and result, walking outwards from the start cell.
    int exp_r[$];
    int exp_c[$];
    bit exp_v[$];
    bit m_win;
    int m_dir;

    task automatic model(input int r0, input int c0, input int pl);
        int dr, dc, sg, cnt, rr, cc;
        bit inb;
        exp_r.delete(); exp_c.delete(); exp_v.delete();
        m_win = 0;
        m_dir = 0;
        if (pl == 0) return;
        for (int d = 0; d < 4; d++) begin
            dr = (d == 0) ? 0 : 1;
            dc = (d == 0 || d == 2) ? 1 : ((d == 1) ? 0 : -1);
            cnt = 1;
            for (int s = 0; s < 2; s++) begin
                sg = (s == 0) ? 1 : -1;
                for (int k = 1; k < WL; k++) begin
                    rr  = r0 + sg * k * dr;
                    cc  = c0 + sg * k * dc;
                    inb = (rr >= 0) && (rr < 8) && (cc >= 0) && (cc < 8);
                    exp_r.push_back(rr & 7);
                    exp_c.push_back(cc & 7);
                    exp_v.push_back(inb);
                    if (!inb) break;
                    if (board[rr][cc] != 2'(pl)) break;
                    cnt++;
                    if (cnt == WL) begin
                        m_win = 1;
                        m_dir = d;
                        return;
                    end
                end
            end
        end
    endtask

    task automatic clear_board();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                board[r][c] = 2'd0;
    endtask

    task automatic setup_board(input int id);
        clear_board();
        case (id)
            1: begin board[0][0] = 2'd1; board[0][1] = 2'd1; board[0][2] = 2'd1; end
            3: begin
                board[2][0] = 2'd1; board[2][1] = 2'd1; board[2][2] = 2'd2;
                board[2][4] = 2'd1; board[2][5] = 2'd1;
            end
            4: begin board[0][3] = 2'd2; board[1][2] = 2'd2; board[2][1] = 2'd2; end
            default: ;
        endcase
    endtask

    // Runs one check request; obs_t is the cycle index (T) in which done was seen, -1 if never.
    task automatic run_scan(input string nm, input int r, input int c, input int pl,
                            input int inj, input bit inj_done,
                            output int obs_t, output int obs_win, output int obs_dir);
        int i;
        if (pl != 0) board[r][c] = 2'(pl);
        model(r, c, pl);
        obs_t = -1; obs_win = -1; obs_dir = -1;
        @(negedge clk);
        start = 1'b1; start_row = 3'(r); start_col = 3'(c); player = 2'(pl);
        @(negedge clk);
        for (int t = 1; t <= 40; t++) begin
            if (t > 1) @(negedge clk);
            start = 1'b0;
            if (done) begin
                obs_t   = t;
                obs_win = int'(win);
`ifdef WIN_DIR_EN
                obs_dir = int'(win_dir);
`else
                obs_dir = m_dir;
`endif
                chk({nm, "_done_rdvalid"}, rd_valid, 0);
                chk({nm, "_done_busy"}, busy, 1);
                if (inj_done) begin
                    start = 1'b1; start_row = 3'd4; start_col = 3'd4; player = 2'd1;
                end
                break;
            end
            i = t - 1;
            if (i < exp_v.size()) begin
                chk({nm, "_busy"}, busy, 1);
                chk({nm, "_rdvalid"}, rd_valid, exp_v[i]);
                if (exp_v[i]) begin
                    chk({nm, "_rdrow"}, rd_row, exp_r[i]);
                    chk({nm, "_rdcol"}, rd_col, exp_c[i]);
                end
            end
            if (t == inj) begin
                start = 1'b1; start_row = 3'd0; start_col = 3'd0; player = 2'd1;
            end
        end
        if (obs_t < 0) chk({nm, "_done_timeout"}, 0, 1);
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_after_done"}, done, 0);
        chk({nm, "_after_busy"}, busy, 0);
        chk({nm, "_win_held"}, win, obs_win);
    endtask

    typedef struct {
        string nm;
        int    setup;
        int    r;
        int    c;
        int    pl;
        int    ewin;
        int    edir;
        int    et;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int ot, ow, od;
        tbl[0] = '{"horiz",  1, 0, 3, 1, 1, 0, 5};
        tbl[1] = '{"empty",  2, 7, 7, 2, 0, 0, 9};
        tbl[2] = '{"broken", 3, 2, 3, 1, 0, 0, 11};
        tbl[3] = '{"anti",   4, 3, 0, 2, 1, 3, 11};
        tbl[4] = '{"nopl",   0, 0, 0, 0, 0, 0, 1};

        start = 1'b0; start_row = 3'd0; start_col = 3'd0; player = 2'd0;
        clear_board();
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_win", win, 0);
        chk("rst_rdvalid", rd_valid, 0);
        chk("rst_rdrow", rd_row, 0);
        chk("rst_rdcol", rd_col, 0);
`ifdef WIN_DIR_EN
        chk("rst_windir", win_dir, 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[n]) begin
            setup_board(tbl[n].setup);
            run_scan(tbl[n].nm, tbl[n].r, tbl[n].c, tbl[n].pl, 0, 1'b0, ot, ow, od);
            chk({tbl[n].nm, "_T"}, ot, tbl[n].et);
            chk({tbl[n].nm, "_win"}, ow, tbl[n].ewin);
`ifdef WIN_DIR_EN
            chk({tbl[n].nm, "_dir"}, od, tbl[n].edir);
`endif
        end

        // start pulse at T3 of a scan must not disturb it
        setup_board(2);
        run_scan("inj_scan", 7, 7, 2, 3, 1'b0, ot, ow, od);
        chk("inj_scan_T", ot, 9);
        chk("inj_scan_win", ow, 0);

        // start in the DONE cycle must not launch a new scan
        setup_board(1);
        run_scan("inj_done", 0, 3, 1, 0, 1'b1, ot, ow, od);
        chk("inj_done_T", ot, 5);
        chk("inj_done_win", ow, 1);
        @(negedge clk);
        chk("inj_done_idle", busy, 0);

        // reset mid-scan: outputs drop at once, no done pulse afterwards
        setup_board(2);
        @(negedge clk);
        start = 1'b1; start_row = 3'd7; start_col = 3'd7; player = 2'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_win", win, 0);
        chk("midrst_rdvalid", rd_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            chk("midrst_no_done", done, 0);
        end

        // random boards against the model
        for (int it = 0; it < 60; it++) begin
            int rr, cc, pl;
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    board[r][c] = ($urandom_range(0, 9) < 6) ? 2'($urandom_range(1, 2)) : 2'd0;
            rr = $urandom_range(0, 7);
            cc = $urandom_range(0, 7);
            pl = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 2);
            run_scan("rand", rr, cc, pl, 0, 1'b0, ot, ow, od);
            chk("rand_T", ot, exp_v.size() + 1);
            chk("rand_win", ow, int'(m_win));
`ifdef WIN_DIR_EN
            chk("rand_dir", od, m_dir);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
